// File: rtl/input_index_encoder.sv
// Encodes a binarized raster image into a FIFO of active-pixel indices; optional activeCount via INDEX_ENCODER_COUNT_EN.
// Latency: an index is visible on queueOut one cycle after its pixel is accepted.
// Backpressure: pixelReady drops from the last pixel until the consumer has drained the queue and HOLD has passed.
module input_index_encoder #(
    parameter int IMAGE_PIXELS = 784,
    parameter int QUEUE_DEPTH  = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixelIn,
    input  logic       pixelValid,
    output logic       pixelReady,
    input  logic       dequeue,
    output logic [9:0] queueOut,
    output logic       queueEmpty,
    output logic       inputsReady
`ifdef INDEX_ENCODER_COUNT_EN
    ,
    output logic [9:0] activeCount
`endif
);

    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int OW = $clog2(QUEUE_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_READY,
        ST_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [9:0]    mem [QUEUE_DEPTH];

    logic accept;
    logic do_write;
    logic do_read;
    logic full;

    assign pixelReady  = reset_n && (state_q == ST_LOAD);
    assign inputsReady = (state_q == ST_READY) || (state_q == ST_HOLD);
    assign queueEmpty  = (occ_q == '0);
    assign full        = (occ_q == OW'(QUEUE_DEPTH));
    assign queueOut    = queueEmpty ? 10'd0 : mem[rd_ptr_q];

    assign accept   = pixelValid && (state_q == ST_LOAD);
    assign do_write = accept && pixelIn && !full;
    assign do_read  = dequeue && !queueEmpty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_write) begin
            wr_ptr_d = (wr_ptr_q == AW'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d = (rd_ptr_q == AW'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_write && !do_read) begin
            occ_d = occ_q + 1'b1;
        end else if (do_read && !do_write) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // READY leaves as soon as the queue will be empty after this edge, which also
    // covers entering READY with nothing stored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_q == 10'(IMAGE_PIXELS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (occ_d == '0) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= cnt_q;
        end
    end

`ifdef INDEX_ENCODER_COUNT_EN
    logic [9:0] act_cnt_q, act_cnt_d;

    always_comb begin
        act_cnt_d = act_cnt_q;
        if (state_q == ST_HOLD) begin
            act_cnt_d = '0;
        end else if (do_write) begin
            act_cnt_d = act_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_cnt_q <= '0;
        end else begin
            act_cnt_q <= act_cnt_d;
        end
    end

    assign activeCount = act_cnt_q;
`endif

endmodule

// File: tb/tb_input_index_encoder.sv
// Directed bench for input_index_encoder: queue-based reference model checked every cycle plus literal pins.
module tb_input_index_encoder;

    localparam int N = 784;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pixelIn = 1'b0;
    logic       pixelValid = 1'b0;
    logic       pixelReady;
    logic       dequeue = 1'b0;
    logic [9:0] queueOut;
    logic       queueEmpty;
    logic       inputsReady;
`ifdef INDEX_ENCODER_COUNT_EN
    logic [9:0] activeCount;
`endif

    input_index_encoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixelIn    (pixelIn),
        .pixelValid (pixelValid),
        .pixelReady (pixelReady),
        .dequeue    (dequeue),
        .queueOut   (queueOut),
        .queueEmpty (queueEmpty),
        .inputsReady(inputsReady)
`ifdef INDEX_ENCODER_COUNT_EN
        ,
        .activeCount(activeCount)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 1'b0;
    bit act [0:N-1];
    int dut_pops[$];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an image is a stream of accepted pixels; active ones queue their index.
    int m_q[$];
    int m_cnt = 0;
    int m_phase = 0; // 0 loading, 1 image complete, 2 one-cycle handoff
    int m_active = 0;
    bit m_acc, m_pop;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_cnt = 0;
            m_phase = 0;
            m_active = 0;
        end else begin
            m_acc = pixelValid && (m_phase == 0);
            m_pop = dequeue && (m_q.size() != 0);
            if (m_pop) void'(m_q.pop_front());
            if (m_acc && pixelIn) begin
                m_q.push_back(m_cnt);
                m_active++;
            end
            if (m_phase == 2) begin
                m_phase = 0;
                m_active = 0;
            end else if (m_phase == 1) begin
                if (m_q.size() == 0) m_phase = 2;
            end else if (m_acc) begin
                if (m_cnt == N - 1) begin
                    m_phase = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pixelReady", int'(pixelReady), int'(reset_n && m_phase == 0));
            chk("queueEmpty", int'(queueEmpty), int'(m_q.size() == 0));
            chk("inputsReady", int'(inputsReady), int'(m_phase != 0));
            if (m_q.size() != 0) chk("queueOut", int'(queueOut), m_q[0]);
`ifdef INDEX_ENCODER_COUNT_EN
            chk("activeCount", int'(activeCount), m_active);
`endif
            if (reset_n && dequeue && !queueEmpty) dut_pops.push_back(int'(queueOut));
        end
    end

    task automatic clear_act();
        for (int i = 0; i < N; i++) act[i] = 1'b0;
    endtask

    task automatic feed(input int n_acc, input bit toggle, input bit deq);
        int cyc = 0;
        int accepted = 0;
        bit take;
        while (accepted < n_acc && cyc < 4000) begin
            pixelValid = toggle ? (cyc % 2 == 0) : 1'b1;
            pixelIn    = act[accepted];
            dequeue    = deq;
            take = pixelValid && pixelReady;
            @(posedge clk); #1;
            if (take) accepted++;
            cyc++;
        end
        pixelValid = 1'b0;
        pixelIn    = 1'b0;
        dequeue    = 1'b0;
        chk("feed_accepts", accepted, n_acc);
    endtask

    task automatic drain();
        int c = 0;
        dequeue = 1'b1;
        while ((inputsReady || !queueEmpty) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        dequeue = 1'b0;
        chk("drain_done", int'(inputsReady || !queueEmpty), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_pops(input string name, input int e[$]);
        chk({name, "_count"}, dut_pops.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < dut_pops.size()) chk({name, "_idx"}, dut_pops[i], e[i]);
        end
    endtask

    initial begin
        int e[$];
        int ir_cycles;

        #2 reset_n = 1'b0;
        started = 1'b1;
        #1;
        chk("rst_pixelReady_low", int'(pixelReady), 0);
        chk("rst_queueEmpty", int'(queueEmpty), 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("reset_pixelReady", int'(pixelReady), 1);
        chk("reset_queueEmpty", int'(queueEmpty), 1);
        chk("reset_inputsReady", int'(inputsReady), 0);
        chk("reset_queueOut", int'(queueOut), 0);
        @(posedge clk); #1;

        // Sparse image: indices 3, 100, 783
        clear_act();
        act[3] = 1'b1; act[100] = 1'b1; act[783] = 1'b1;
        dut_pops.delete();
        feed(N, 1'b0, 1'b0);
        chk("s1_inputsReady_after_last", int'(inputsReady), 1);
        chk("s1_head", int'(queueOut), 3);
`ifdef INDEX_ENCODER_COUNT_EN
        chk("s1_activeCount", int'(activeCount), 3);
`endif
        idle(3);
        chk("s1_ready_holds", int'(inputsReady), 1);
        drain();
        e = '{3, 100, 783};
        check_pops("s1_pops", e);
        idle(2);

        // All-zero image: READY and HOLD last one cycle each
        clear_act();
        feed(N, 1'b0, 1'b0);
        ir_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (inputsReady) ir_cycles++;
            @(posedge clk); #1;
        end
        chk("s2_inputsReady_cycles", ir_cycles, 2);
        chk("s2_pixelReady_back", int'(pixelReady), 1);

        // Alternating valid, only index 0 active
        clear_act();
        act[0] = 1'b1;
        dut_pops.delete();
        feed(N, 1'b1, 1'b0);
        chk("s3_inputsReady", int'(inputsReady), 1);
        drain();
        e = '{0};
        check_pops("s3_pops", e);
        idle(2);

        // Consumer drains while the image is loading
        clear_act();
        for (int i = 10; i < 20; i++) act[i] = 1'b1;
        dut_pops.delete();
        feed(N, 1'b0, 1'b1);
        idle(4);
        e = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
        check_pops("s4_pops", e);
        chk("s4_back_to_load", int'(pixelReady), 1);

        // Reset after pixel 400 discards the partial image
        clear_act();
        act[5] = 1'b1; act[200] = 1'b1; act[399] = 1'b1;
        feed(401, 1'b0, 1'b0);
        chk("s5_queue_nonempty", int'(queueEmpty), 0);
        reset_n = 1'b0;
        #1;
        chk("s5_rst_queueEmpty", int'(queueEmpty), 1);
        chk("s5_rst_pixelReady", int'(pixelReady), 0);
        chk("s5_rst_inputsReady", int'(inputsReady), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        clear_act();
        act[7] = 1'b1; act[500] = 1'b1;
        dut_pops.delete();
        feed(N, 1'b0, 1'b0);
        drain();
        e = '{7, 500};
        check_pops("s5_pops", e);
        idle(2);

        // Dequeue on an empty queue is ignored
        dequeue = 1'b1;
        idle(5);
        dequeue = 1'b0;
        chk("s6_empty_deq", int'(queueEmpty), 1);
        clear_act();
        act[42] = 1'b1; act[600] = 1'b1;
        dut_pops.delete();
        feed(N, 1'b0, 1'b0);
        chk("s6_head", int'(queueOut), 42);
        drain();
        e = '{42, 600};
        check_pops("s6_pops", e);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_index_encoder.md
INPUT_INDEX_ENCODER -- requirements
Module: input_index_encoder

Interface
REQ-001 SHALL have parameter IMAGE_PIXELS, default 784, pixels per image in raster order.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 1024, index FIFO entries; QUEUE_DEPTH >= IMAGE_PIXELS.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port pixelIn  in  1  binarized pixel value (1 = active).
REQ-006 SHALL have port pixelValid  in  1  pixelIn valid this cycle.
REQ-007 SHALL have port pixelReady  out  1  encoder accepts a pixel this cycle.
REQ-008 SHALL have port dequeue  in  1  consumer pops the head index.
REQ-009 SHALL have port queueOut  out  10  head pixel index, first-word fall-through.
REQ-010 SHALL have port queueEmpty  out  1  FIFO holds no index.
REQ-011 SHALL have port inputsReady  out  1  full image encoded; queue contents final.

Function
REQ-012 SHALL accept a pixel on a rising edge where pixelValid and pixelReady are both 1; no other pixel transfer exists.
REQ-013 SHALL keep a pixel counter 0..IMAGE_PIXELS-1, incremented per accepted pixel; its value is the accepted pixel's index.
REQ-014 SHALL write the current counter value into the FIFO when an accepted pixel has pixelIn = 1; pixelIn = 0 pixels write nothing.
REQ-015 SHALL implement states LOAD, READY, HOLD; pixelReady = 1 only in LOAD; inputsReady = 1 only in READY and HOLD.
REQ-016 LOAD -> READY on acceptance of pixel index IMAGE_PIXELS-1; counter wraps to 0 on that edge.
REQ-017 READY -> HOLD on the edge where the FIFO becomes empty, or immediately on the next edge if entered with an empty FIFO (all-zero image).
REQ-018 HOLD SHALL last exactly one cycle with queueEmpty = 1 and inputsReady = 1, then go to LOAD; this lets the consumer observe the last-pixel condition.
REQ-019 queueOut SHALL show the oldest stored index combinationally from FIFO storage whenever queueEmpty = 0; value is don't-care when empty.
REQ-020 dequeue with queueEmpty = 0 SHALL advance the read pointer on that edge; dequeue with queueEmpty = 1 SHALL be ignored.
REQ-021 Simultaneous write and dequeue SHALL both take effect; occupancy unchanged; a write into an empty FIFO is visible on queueOut the next cycle.
REQ-022 Read/write pointers SHALL wrap modulo QUEUE_DEPTH; occupancy counter width clog2(QUEUE_DEPTH)+1.
REQ-023 FIFO full cannot occur under REQ-002; writes when full SHALL be dropped and never corrupt stored entries.
REQ-024 dequeue is legal in any state; the consumer may drain during LOAD (pipelined operation).

Reset
REQ-025 reset_n = 0 SHALL immediately force state LOAD, counter 0, pointers and occupancy 0.
REQ-026 Reset values: pixelReady 1 (0 while reset_n = 0), queueEmpty 1, inputsReady 0, queueOut 0.
REQ-027 Reset mid-image or mid-drain SHALL discard all stored indices; the next accepted pixel is index 0.
REQ-028 FIFO storage array need not be reset.

Configuration
REQ-029 Macro INDEX_ENCODER_COUNT_EN SHALL be the only compile-time option.
REQ-030 With INDEX_ENCODER_COUNT_EN defined: extra output activeCount  out  10  number of active pixels written for the current image; cleared on LOAD entry from HOLD and on reset; held stable in READY and HOLD.
REQ-031 Without INDEX_ENCODER_COUNT_EN: port activeCount and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, then 784 pixels, pixelValid = 1 every cycle, pixelIn = 1 at indices 3, 100, 783 -> inputsReady rises the cycle after index 783; queueOut shows 3, 100, 783 in order under dequeue; activeCount = 3 if enabled.
REQ-033 All-zero image -> queueEmpty stays 1; inputsReady = 1 for exactly 2 cycles (READY, HOLD); then pixelReady = 1.
REQ-034 pixelValid toggled 1/0 every cycle with pixelIn = 1 at index 0 only -> acceptance count is exact; READY entered after 784 accepts.
REQ-035 Dequeue held high during LOAD of an image with pixelIn = 1 at indices 10..19 -> each index delivered once, in order; write and dequeue coincide without loss.
REQ-036 reset_n low for 1 cycle after pixel 400 of an image with active pixels -> queueEmpty = 1 immediately; next image's first active index reported correctly from 0.
REQ-037 dequeue asserted while queueEmpty = 1 -> no pointer change; subsequent image's first index correct.
